mem_arbiter: RTL

Two-port arbiter and sequencer for the single-ported 256×16 instruction/data RAM. It shares the RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write). It decides who gets each access, sequences the RAM control strobes, registers read data, and rejects out-of-range addresses. It sits between the CPU's fetch/LSU stages and the RAM's DataAddress/ReadMem/WriteMem/DataIn/DataOut pins.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 27 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the instruction/data RAM arbiter
package mem_arb_pkg;

    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_e;

    // Requester ID doubles as the bit index into the one-hot grant vector
    typedef logic reqId_t;
    localparam reqId_t REQ_FETCH = 1'b0;
    localparam reqId_t REQ_DATA  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       fetchReq,
    input  logic       dataReq,
    input  reqId_t     lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (fetchReq && dataReq) begin
            // On a tie the port that was not served last goes next
            if (lastGrant == REQ_DATA) begin
                grant[REQ_FETCH] = 1'b1;
            end else begin
                grant[REQ_DATA] = 1'b1;
            end
        end else if (fetchReq) begin
            grant[REQ_FETCH] = 1'b1;
        end else if (dataReq) begin
            grant[REQ_DATA] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-ported RAM between instruction fetch and the LSU
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchAck,
    output logic [DATA_W-1:0] FetchData,

    input  logic              DataReq,
    input  logic              DataWrite,
    input  logic [ADDR_W-1:0] DataAddr,
    input  logic [DATA_W-1:0] DataWdata,
    output logic              DataAck,
    output logic [DATA_W-1:0] DataRdata,

    output logic              AddrErr,

    output logic [ADDR_W-1:0] MemAddress,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

    arbState_e         state;
    reqId_t            lastGrant;

    reqId_t            reqId;
    logic              reqWrite;
    logic              reqErr;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;

    logic [1:0]        grant;
    reqId_t            winner;
    logic              anyReq;
    logic [ADDR_W-1:0] selAddr;
    logic              selWrite;
    logic              selErr;
    logic              inAccess;
    logic [DATA_W-1:0] readValue;

    rr_arb2 arb (
        .fetchReq  (FetchReq),
        .dataReq   (DataReq),
        .lastGrant (lastGrant),
        .grant     (grant)
    );

    always_comb begin
        anyReq   = FetchReq | DataReq;
        winner   = grant[REQ_DATA] ? REQ_DATA : REQ_FETCH;
        selAddr  = (winner == REQ_DATA) ? DataAddr : FetchAddr;
        selWrite = (winner == REQ_DATA) & DataWrite;
        selErr   = ({1'b0, selAddr} >= ADDR_LIMIT);
    end

    // RAM strobes are gated by reset so a reset landing in ACCESS cannot commit a write
    always_comb begin
        inAccess   = (state == ACCESS) & ~reset;
        MemRead    = inAccess & ~reqWrite & ~reqErr;
        MemWrite   = inAccess &  reqWrite & ~reqErr;
        MemAddress = inAccess ? reqAddr : '0;
        MemDataIn  = (inAccess & reqWrite) ? reqWdata : '0;
        readValue  = (reqWrite | reqErr) ? '0 : MemDataOut;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= REQ_DATA;
            reqId     <= REQ_FETCH;
            reqWrite  <= 1'b0;
            reqErr    <= 1'b0;
            reqAddr   <= '0;
            reqWdata  <= '0;
            FetchAck  <= 1'b0;
            DataAck   <= 1'b0;
            AddrErr   <= 1'b0;
            FetchData <= '0;
            DataRdata <= '0;
        end else begin
            FetchAck <= 1'b0;
            DataAck  <= 1'b0;
            AddrErr  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        reqId     <= winner;
                        reqWrite  <= selWrite;
                        reqErr    <= selErr;
                        reqAddr   <= selAddr;
                        reqWdata  <= DataWdata;
                        lastGrant <= winner;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Responses are loaded at the closing edge so they are visible throughout RESP
                    if (reqId == REQ_FETCH) begin
                        FetchAck  <= 1'b1;
                        FetchData <= readValue;
                    end else begin
                        DataAck   <= 1'b1;
                        DataRdata <= readValue;
                    end
                    AddrErr <= reqErr;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
